// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI-S width-conversion FIFOs: read-unit state
// encodings, lane-count type and a constant log2 helper.
package axis_fifo_pkg;

    // Widest lane count supported (RATIO up to 64).
    localparam int LANE_CNT_MAX_W = 6;

    typedef logic [LANE_CNT_MAX_W-1:0] lane_cnt_t;

    typedef enum logic [0:0] {
        READ_IDLE = 1'b0,
        READ_BUSY = 1'b1
    } read_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_nto1_packet_unpack.sv
// nto1_unpack: holds one wide entry and emits its lanes 0..count one per
// accepted cycle, reloading from the prefetch register without a bubble.
module nto1_unpack
    import axis_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RATIO = 16,
    parameter int CBITS = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pf_vld_i,
    input  logic                   pf_last_i,
    input  logic [CBITS-1:0]       pf_count_i,
    input  logic [WIDTH*RATIO-1:0] pf_data_i,
    output logic                   pf_take_o,
    output logic                   final_o,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic                   last_o,
    output logic [WIDTH-1:0]       data_o
);

    read_state_e              state_q, state_d;
    logic [CBITS-1:0]         lane_q, lane_d;
    logic [CBITS-1:0]         count_q, count_d;
    logic                     last_q, last_d;
    logic [WIDTH*RATIO-1:0]   data_q, data_d;
    logic                     at_end;

    assign at_end = (lane_q == count_q);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        count_d   = count_q;
        last_d    = last_q;
        data_d    = data_q;
        pf_take_o = 1'b0;
        final_o   = 1'b0;

        if (state_q == READ_IDLE) begin
            if (pf_vld_i) begin
                pf_take_o = 1'b1;
                state_d   = READ_BUSY;
            end
        end else if (ready_i) begin
            if (at_end) begin
                final_o = 1'b1;
                if (pf_vld_i) begin
                    pf_take_o = 1'b1;
                end else begin
                    state_d = READ_IDLE;
                end
            end else begin
                lane_d = lane_q + CBITS'(1);
                // Lane 0 always sits in the low bits; shift the next one down.
                data_d = data_q >> WIDTH;
            end
        end

        if (pf_take_o) begin
            lane_d  = '0;
            count_d = pf_count_i;
            last_d  = pf_last_i;
            data_d  = pf_data_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= READ_IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    always_ff @(posedge clock) begin
        count_q <= count_d;
        last_q  <= last_d;
        data_q  <= data_d;
    end

    assign valid_o = (state_q == READ_BUSY);
    assign last_o  = valid_o && last_q && at_end;
    assign data_o  = valid_o ? data_q[WIDTH-1:0] : '0;

endmodule

// File: rtl/fifo_nto1_packet.sv
// Wide-to-narrow packet FIFO: RATIO-lane entries with lane count and EOP flag,
// emitted one lane per cycle. Define FIFO_NTO1_LEVEL_EN to add level_o.
module fifo_nto1_packet
    import axis_fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int RATIO = 16,
    parameter  int ABITS = 4,
    localparam int CBITS = clog2(RATIO)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   last_i,
    input  logic [CBITS-1:0]       count_i,
    input  logic [WIDTH*RATIO-1:0] data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o,
    output logic [WIDTH-1:0]       data_o
`ifdef FIFO_NTO1_LEVEL_EN
    ,
    output logic [ABITS:0]         level_o
`endif
);

    localparam int DEPTH = 1 << ABITS;
    localparam int DW    = WIDTH * RATIO;
    localparam int EW    = 1 + CBITS + DW;
    localparam logic [ABITS:0] FULL_LEVEL = (ABITS+1)'(DEPTH);

    logic [EW-1:0]  mem_q [DEPTH];
    logic [ABITS:0] wptr_q, wptr_d;
    logic [ABITS:0] rptr_q, rptr_d;
    logic [ABITS:0] fptr_q, fptr_d;
    logic [ABITS:0] used_d;
    logic           ready_q, ready_d;
    logic [EW-1:0]  pf_entry_q;
    logic           pf_vld_q, pf_vld_d;
    logic           wr_en, rd_en, empty;
    logic           pf_take, final_xfer;

    assign wr_en = valid_i && ready_q;
    assign empty = (rptr_q == wptr_q);
    assign rd_en = !empty && (!pf_vld_q || pf_take);

    // fptr trails rptr: a slot stays occupied until its last lane is
    // transferred, so entries in prefetch and unpack still count as stored.
    always_comb begin
        wptr_d   = wptr_q + (ABITS+1)'(wr_en);
        rptr_d   = rptr_q + (ABITS+1)'(rd_en);
        fptr_d   = fptr_q + (ABITS+1)'(final_xfer);
        pf_vld_d = pf_vld_q;
        if (rd_en) begin
            pf_vld_d = 1'b1;
        end else if (pf_take) begin
            pf_vld_d = 1'b0;
        end
        used_d  = wptr_d - fptr_d;
        ready_d = (used_d != FULL_LEVEL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            fptr_q   <= '0;
            ready_q  <= 1'b0;
            pf_vld_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            fptr_q   <= fptr_d;
            ready_q  <= ready_d;
            pf_vld_q <= pf_vld_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wptr_q[ABITS-1:0]] <= {last_i, count_i, data_i};
        end
    end

    always_ff @(posedge clock) begin
        if (rd_en) begin
            pf_entry_q <= mem_q[rptr_q[ABITS-1:0]];
        end
    end

    assign ready_o = ready_q;

    nto1_unpack #(
        .WIDTH (WIDTH),
        .RATIO (RATIO),
        .CBITS (CBITS)
    ) u_unpack (
        .clock      (clock),
        .reset      (reset),
        .pf_vld_i   (pf_vld_q),
        .pf_last_i  (pf_entry_q[EW-1]),
        .pf_count_i (pf_entry_q[DW +: CBITS]),
        .pf_data_i  (pf_entry_q[DW-1:0]),
        .pf_take_o  (pf_take),
        .final_o    (final_xfer),
        .ready_i    (ready_i),
        .valid_o    (valid_o),
        .last_o     (last_o),
        .data_o     (data_o)
    );

`ifdef FIFO_NTO1_LEVEL_EN
    logic [ABITS:0] level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= used_d;
        end
    end

    assign level_o = level_q;
`endif

endmodule

// File: tb/tb_fifo_nto1_packet.sv
// Directed + randomized bench for fifo_nto1_packet against a lane-queue model.
module tb_fifo_nto1_packet;

    localparam int WIDTH = 8;
    localparam int RATIO = 16;
    localparam int ABITS = 4;
    localparam int CBITS = 4;
    localparam int DW    = WIDTH * RATIO;

    logic             clock;
    logic             reset;
    logic             valid_i;
    logic             ready_o;
    logic             last_i;
    logic [CBITS-1:0] count_i;
    logic [DW-1:0]    data_i;
    logic             valid_o;
    logic             ready_i;
    logic             last_o;
    logic [WIDTH-1:0] data_o;
`ifdef FIFO_NTO1_LEVEL_EN
    logic [ABITS:0]   level_o;
`endif

    fifo_nto1_packet #(
        .WIDTH (WIDTH),
        .RATIO (RATIO),
        .ABITS (ABITS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .last_i  (last_i),
        .count_i (count_i),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o),
        .data_o  (data_o)
`ifdef FIFO_NTO1_LEVEL_EN
        ,
        .level_o (level_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp_q[$];
    logic       accepted;
    logic       rand_ready = 1'b0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_word;
    int         cyc = 0;
    int         xfer_cnt = 0;
    int         first_cyc = -1;
    int         last_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        xfer_cnt  = 0;
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    // One clock: book handshakes seen before the edge, then advance to 1ns after it.
    task automatic cycle();
        logic [8:0] e;
        if (rand_ready) ready_i = 1'($urandom_range(0, 1));
        accepted = 1'b0;
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(valid_o), 32'd1);
                chk("stall_data", 32'({last_o, data_o}), 32'(prev_word));
            end
            if (valid_i && ready_o) begin
                accepted = 1'b1;
                for (int l = 0; l <= int'(count_i); l++)
                    exp_q.push_back({last_i && (l == int'(count_i)), data_i[l*WIDTH +: WIDTH]});
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("xfer_without_expected_lane", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("lane", 32'({last_o, data_o}), 32'(e));
                end
                xfer_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            prev_stall = valid_o && !ready_i;
            prev_word  = {last_o, data_o};
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic send_word(input logic l, input logic [CBITS-1:0] c, input logic [DW-1:0] d);
        int n;
        n = 0;
        valid_i = 1'b1;
        last_i  = l;
        count_i = c;
        data_i  = d;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 2000);
        chk("accept", 32'(accepted), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        valid_i = 1'b0;
        while ((exp_q.size() != 0 || valid_o) && n < 5000) begin
            cycle();
            n++;
        end
        chk({tag, "_model_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_valid_low"}, 32'(valid_o), 32'd0);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;
        int n;

        reset = 1'b1; valid_i = 1'b0; last_i = 1'b0; count_i = '0; data_i = '0; ready_i = 1'b1;

        // Reset state
        repeat (3) cycle();
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
`ifdef FIFO_NTO1_LEVEL_EN
        chk("rst_level", 32'(level_o), 32'd0);
`endif
        reset = 1'b0;
        chk("ready_before_edge", 32'(ready_o), 32'd0);
        cycle();
        chk("ready_after_reset", 32'(ready_o), 32'd1);

        // Test 1: reset in the middle of a packet
        clear_stats();
        send_word(1'b1, 4'hF, rand_word());
        valid_i = 1'b0;
        n = 0;
        while (xfer_cnt < 5 && n < 100) begin cycle(); n++; end
        chk("t1_partial_lanes", 32'(xfer_cnt), 32'd5);
        reset = 1'b1;
        cycle();
        chk("t1_rst_valid", 32'(valid_o), 32'd0);
        chk("t1_rst_last", 32'(last_o), 32'd0);
        chk("t1_rst_ready", 32'(ready_o), 32'd0);
        chk("t1_rst_data", 32'(data_o), 32'd0);
        reset = 1'b0;
        chk("t1_ready_still_low", 32'(ready_o), 32'd0);
        cycle();
        chk("t1_ready_rise", 32'(ready_o), 32'd1);
        send_word(1'b0, 4'hF, rand_word());
        send_word(1'b1, 4'h7, rand_word());
        drain("t1");

        // Test 2: three full words 0x00..0x2F, gap-free
        clear_stats();
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < RATIO; l++) w[l*WIDTH +: WIDTH] = 8'(k * 16 + l);
            send_word(k == 2, 4'hF, w);
        end
        drain("t2");
        chk("t2_lane_count", 32'(xfer_cnt), 32'd48);
        chk("t2_no_gaps", 32'(last_cyc - first_cyc), 32'd47);

        // Test 3: partial word, plus two-edge write latency
        clear_stats();
        for (int l = 0; l < RATIO; l++) w[l*WIDTH +: WIDTH] = 8'(8'hA0 + l);
        send_word(1'b1, 4'd4, w);
        valid_i = 1'b0;
        chk("t3_lat_edge1", 32'(valid_o), 32'd0);
        cycle();
        chk("t3_lat_edge2", 32'(valid_o), 32'd0);
        cycle();
        chk("t3_lat_valid", 32'(valid_o), 32'd1);
        chk("t3_lat_data", 32'(data_o), 32'hA0);
        drain("t3");
        chk("t3_lane_count", 32'(xfer_cnt), 32'd5);

        // Test 6: single-lane non-final word followed by a full word
        clear_stats();
        send_word(1'b0, 4'd0, rand_word());
        send_word(1'b1, 4'hF, rand_word());
        drain("t6");
        chk("t6_lane_count", 32'(xfer_cnt), 32'd17);

        // Test 4: fill to full, simultaneous final-lane read and write attempt
        clear_stats();
        ready_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            send_word(1'b1, 4'hF, rand_word());
            if (k == 14) chk("t4_ready_at_15", 32'(ready_o), 32'd1);
        end
        valid_i = 1'b0;
        chk("t4_full_ready", 32'(ready_o), 32'd0);
`ifdef FIFO_NTO1_LEVEL_EN
        chk("t4_full_level", 32'(level_o), 32'd16);
`endif
        valid_i = 1'b1; last_i = 1'b1; count_i = 4'hF; data_i = rand_word();
        cycle();
        chk("t4_refused_when_full", 32'(accepted), 32'd0);
        ready_i = 1'b1;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (accepted) n++;
            if (k == 14) chk("t4_ready_before_free", 32'(ready_o), 32'd0);
        end
        chk("t4_no_accept_while_full", 32'(n), 32'd0);
        chk("t4_ready_after_free", 32'(ready_o), 32'd1);
        cycle();
        chk("t4_accept_next_cycle", 32'(accepted), 32'd1);
        valid_i = 1'b0;
`ifdef FIFO_NTO1_LEVEL_EN
        chk("t4_level_after_refill", 32'(level_o), 32'd16);
`endif
        drain("t4");

        // Test 5: random packets with random backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 200; p++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                send_word(k == n - 1, 4'($urandom_range(0, 15)), rand_word());
                if ($urandom_range(0, 3) == 0) begin
                    valid_i = 1'b0;
                    cycle();
                end
            end
        end
        drain("t5");
        rand_ready = 1'b0;
        ready_i = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
